// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Binds active notes from the keypad decoder and the loop playback engine
// to NUM_VOICES shared tone-generator slots. A 4-bit scan index walks the
// 16 note positions continuously, one index per cycle. An active note that
// no slot holds yet is given the lowest free slot. Every cycle, in parallel,
// slots whose note is no longer requested are released, and the owner
// (keypad or looper) of each held note is refreshed.
//
// Optional feature (macro VOICE_STEAL_EN): when no slot is free, a keypad
// note may take over the oldest looper-owned slot. Ties go to the lowest
// slot index. With the macro undefined, an unplaceable note only pulses
// `dropped`.
//
// Parameters:
//   NUM_VOICES  number of voice slots (1..8)
//   AGE_W       width of the per-slot saturating age counter
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   keypad_vector  held keypad notes, bit n = note n
//   looper_vector  notes requested by loop playback
//   voice_valid    slot i is bound to a note
//   voice_note     note index of slot i in bits [4i+3:4i]
//   voice_src      1 = slot i owned by keypad, 0 = owned by looper
//   dropped        one-cycle pulse, a scanned note could not get a slot
//   scan_done      one-cycle pulse, scan index 15 was processed
// -----------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             keypad_vector,
    input  logic [15:0]             looper_vector,
    output logic [NUM_VOICES-1:0]   voice_valid,
    output logic [4*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_src,
    output logic                    dropped,
    output logic                    scan_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    state_t                state_reg, state_next;
    logic [3:0]            idx_reg, idx_next;
    logic [NUM_VOICES-1:0] valid_reg, valid_next;
    logic [NUM_VOICES-1:0] src_reg, src_next;
    logic [3:0]            note_reg [NUM_VOICES];
    logic [3:0]            note_next [NUM_VOICES];
    logic [AGE_W-1:0]      age_reg [NUM_VOICES];
    logic [AGE_W-1:0]      age_next [NUM_VOICES];
    logic                  dropped_reg, dropped_next;
    logic                  scan_done_reg, scan_done_next;

    logic [15:0]           req;
    logic [NUM_VOICES-1:0] slot_req;   // slot's note is still requested
    logic [NUM_VOICES-1:0] slot_kp;    // slot's note is held on the keypad
    logic [NUM_VOICES-1:0] slot_hit;   // slot already holds the scanned note

    logic                  free_found;
    int                    free_slot;
    logic                  steal_found;
    int                    steal_slot;
    logic                  alloc_en;
    int                    alloc_slot;

    assign req = keypad_vector | looper_vector;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
            assign slot_req[gi]          = req[note_reg[gi]];
            assign slot_kp[gi]           = keypad_vector[note_reg[gi]];
            assign slot_hit[gi]          = valid_reg[gi] && (note_reg[gi] == idx_reg);
            assign voice_note[4*gi +: 4] = note_reg[gi];
        end
    endgenerate

    // Lowest-numbered free slot, judged on the registered valid bits so a
    // slot released this cycle is only reusable from the next cycle on.
    always_comb begin
        free_found = 1'b0;
        free_slot  = 0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_found = 1'b1;
                free_slot  = i;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0] steal_age;

    // Oldest looper-owned slot; strict '>' keeps the lowest index on ties.
    always_comb begin
        steal_found = 1'b0;
        steal_slot  = 0;
        steal_age   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (valid_reg[i] && !src_reg[i] &&
                (!steal_found || (age_reg[i] > steal_age))) begin
                steal_found = 1'b1;
                steal_slot  = i;
                steal_age   = age_reg[i];
            end
        end
    end
`else
    assign steal_found = 1'b0;
    assign steal_slot  = 0;
`endif

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        dropped_next   = 1'b0;
        scan_done_next = 1'b0;
        alloc_en       = 1'b0;
        alloc_slot     = 0;

        case (state_reg)
            IDLE: begin
                state_next = SCAN;
                idx_next   = 4'd0;
            end
            SCAN: begin
                idx_next       = idx_reg + 4'd1;
                scan_done_next = (idx_reg == 4'd15);
                if (req[idx_reg] && !(|slot_hit)) begin
                    if (free_found) begin
                        alloc_en   = 1'b1;
                        alloc_slot = free_slot;
                    end else if (keypad_vector[idx_reg] && steal_found) begin
                        alloc_en   = 1'b1;
                        alloc_slot = steal_slot;
                    end else begin
                        dropped_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 4'd0;
            end
        endcase

        for (int i = 0; i < NUM_VOICES; i++) begin
            valid_next[i] = valid_reg[i];
            note_next[i]  = note_reg[i];
            src_next[i]   = src_reg[i];
            age_next[i]   = age_reg[i];
            // Release has priority: a steal aimed at a slot whose own note
            // just went away is simply lost, the slot goes free.
            if (valid_reg[i] && !slot_req[i]) begin
                valid_next[i] = 1'b0;
                age_next[i]   = '0;
            end else if (alloc_en && (alloc_slot == i)) begin
                valid_next[i] = 1'b1;
                note_next[i]  = idx_reg;
                src_next[i]   = keypad_vector[idx_reg];
                age_next[i]   = '0;
            end else if (valid_reg[i]) begin
                if (age_reg[i] != AGE_MAX) begin
                    age_next[i] = age_reg[i] + 1'b1;
                end
                // Note is still requested: keypad if held there, else looper.
                src_next[i] = slot_kp[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= 4'd0;
            valid_reg     <= '0;
            src_reg       <= '0;
            dropped_reg   <= 1'b0;
            scan_done_reg <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_reg[i] <= 4'd0;
                age_reg[i]  <= '0;
            end
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            valid_reg     <= valid_next;
            src_reg       <= src_next;
            dropped_reg   <= dropped_next;
            scan_done_reg <= scan_done_next;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_reg[i] <= note_next[i];
                age_reg[i]  <= age_next[i];
            end
        end
    end

    assign voice_valid = valid_reg;
    assign voice_src   = src_reg;
    assign dropped     = dropped_reg;
    assign scan_done   = scan_done_reg;

endmodule
